// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : mc_controller_if
// Purpose : Bundles the decoded instruction fields, ALU flags and memory
//           handshake going into the multicycle sequencer, together with
//           every datapath select / write enable it drives.
// Modports:
//   master - the sequencer (consumes instruction fields, drives controls)
//   slave  - datapath / memory side (supplies fields, consumes controls)
// Signals : cond[3:0] op[1:0] funct[5:0] rd[3:0] alu_flags[3:0] mem_ready
//           ir_write pc_write pc_src adr_src mem_req mem_write reg_write
//           mem_to_reg alu_src imm_src[1:0] reg_src[1:0] alu_control[2:0]
//           shift_flag illegal
// Revision: 1.0 - initial release
// ============================================================================
interface mc_controller_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [2:0] alu_control;
  logic       shift_flag;
  logic       illegal;

  modport master (
    input  cond, op, funct, rd, alu_flags, mem_ready,
    output ir_write, pc_write, pc_src, adr_src, mem_req, mem_write,
           reg_write, mem_to_reg, alu_src, imm_src, reg_src,
           alu_control, shift_flag, illegal
  );

  modport slave (
    output cond, op, funct, rd, alu_flags, mem_ready,
    input  ir_write, pc_write, pc_src, adr_src, mem_req, mem_write,
           reg_write, mem_to_reg, alu_src, imm_src, reg_src,
           alu_control, shift_flag, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : mc_controller
// Purpose : Multicycle sequencer for the ARM-subset datapath. Decodes
//           cond/op/funct/rd one instruction at a time, owns the NZCV flag
//           register and drives every datapath select / write enable, with a
//           memory-ready handshake on fetch, load and store.
// Ports   : clk   - clock, all state on rising edge
//           reset - asynchronous, active-low
//           bus   - mc_controller_if.master (instruction fields, flags,
//                   mem_ready in; all control strobes out)
// Params  : FLAG_RST - reset value of the NZCV flag register
// Revision: 1.0 - initial release
// ============================================================================
module mc_controller #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_ORR = 3'b011;
  localparam logic [2:0] C_ALU_EOR = 3'b100;

  localparam logic [3:0] C_CMD_ADD = 4'b0100;
  localparam logic [3:0] C_CMD_SUB = 4'b0010;
  localparam logic [3:0] C_CMD_CMP = 4'b1010;
  localparam logic [3:0] C_CMD_AND = 4'b0000;
  localparam logic [3:0] C_CMD_ORR = 4'b1100;
  localparam logic [3:0] C_CMD_EOR = 4'b0001;
  localparam logic [3:0] C_CMD_MOV = 4'b1101;

  state_t     r_state, w_next;
  logic [3:0] r_flags;      // {N, Z, C, V}
  logic       r_cond_ex;    // condition result frozen at end of DECODE
  logic       w_cond_ex;
  logic [3:0] w_cmd;
  logic       w_cmd_ok, w_is_arith, w_is_cmp, w_is_mov;
  logic [2:0] w_alu_ctl;
  logic       w_rd_pc;

  assign w_cmd   = bus.funct[4:1];
  assign w_rd_pc = (bus.rd == 4'd15);

  // Condition evaluation against the architectural flag register
  always_comb begin
    w_cond_ex = 1'b0;
    case (bus.cond)
      4'b0000: w_cond_ex =  r_flags[2];
      4'b0001: w_cond_ex = ~r_flags[2];
      4'b0010: w_cond_ex =  r_flags[1];
      4'b0011: w_cond_ex = ~r_flags[1];
      4'b0100: w_cond_ex =  r_flags[3];
      4'b0101: w_cond_ex = ~r_flags[3];
      4'b0110: w_cond_ex =  r_flags[0];
      4'b0111: w_cond_ex = ~r_flags[0];
      4'b1000: w_cond_ex =  r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_ex = ~r_flags[1] |  r_flags[2];
      4'b1010: w_cond_ex =  (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_ex =  (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_ex =  r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_ex =  1'b1;
      default: w_cond_ex =  1'b0;  // 1111: never
    endcase
  end

  // Data-processing command decode
  always_comb begin
    w_cmd_ok   = 1'b1;
    w_is_arith = 1'b0;
    w_is_cmp   = 1'b0;
    w_is_mov   = 1'b0;
    w_alu_ctl  = C_ALU_ADD;
    case (w_cmd)
      C_CMD_ADD: w_is_arith = 1'b1;
      C_CMD_SUB: begin w_alu_ctl = C_ALU_SUB; w_is_arith = 1'b1; end
      C_CMD_CMP: begin w_alu_ctl = C_ALU_SUB; w_is_arith = 1'b1; w_is_cmp = 1'b1; end
      C_CMD_AND: w_alu_ctl = C_ALU_AND;
      C_CMD_ORR: w_alu_ctl = C_ALU_ORR;
      C_CMD_EOR: w_alu_ctl = C_ALU_EOR;
      C_CMD_MOV: w_is_mov  = 1'b1;
      default:   w_cmd_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_RST;
      r_flags   <= FLAG_RST;
      r_cond_ex <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_cond_ex <= w_cond_ex;
      // Logical ops and MOV leave C and V untouched
      if (r_state == S_EXEC && bus.funct[0] && r_cond_ex && w_cmd_ok) begin
        r_flags[3:2] <= bus.alu_flags[3:2];
        if (w_is_arith)
          r_flags[1:0] <= bus.alu_flags[1:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          2'b00:   w_next = S_EXEC;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      // A squashed store never touches memory, so it need not wait
      S_MEMWR:  w_next = (!r_cond_ex || bus.mem_ready) ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = w_cmd_ok ? S_ALUWB : S_FETCH;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_RST;
    endcase
  end

  always_comb begin
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.adr_src     = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src     = 1'b0;
    bus.imm_src     = 2'b00;
    bus.reg_src     = 2'b00;
    bus.alu_control = C_ALU_ADD;
    bus.shift_flag  = 1'b0;
    bus.illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_DECODE: begin
        bus.reg_src[0] = (bus.op == 2'b10);
        bus.reg_src[1] = (bus.op == 2'b01);
        bus.illegal    = (bus.op == 2'b11);
      end
      S_MEMADR: begin
        bus.alu_src     = 1'b1;
        bus.imm_src     = 2'b01;
        bus.alu_control = bus.funct[4] ? C_ALU_ADD : C_ALU_SUB;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = r_cond_ex;
        bus.mem_to_reg = r_cond_ex;
        bus.pc_src     = r_cond_ex & w_rd_pc;
        bus.pc_write   = r_cond_ex & w_rd_pc;
      end
      S_MEMWR: begin
        bus.mem_req   = r_cond_ex;
        bus.adr_src   = 1'b1;
        bus.mem_write = r_cond_ex;
      end
      S_EXEC: begin
        bus.alu_src     = bus.funct[5];
        bus.alu_control = w_alu_ctl;
        bus.shift_flag  = w_is_mov;
        bus.illegal     = ~w_cmd_ok;
      end
      S_ALUWB: begin
        // ALU inputs stay steered so the result is still valid for writeback
        bus.alu_src     = bus.funct[5];
        bus.alu_control = w_alu_ctl;
        bus.shift_flag  = w_is_mov;
        bus.reg_write   = r_cond_ex & ~w_is_cmp;
        bus.pc_src      = r_cond_ex & ~w_is_cmp & w_rd_pc;
        bus.pc_write    = r_cond_ex & ~w_is_cmp & w_rd_pc;
      end
      S_BRANCH: begin
        bus.alu_src  = 1'b1;
        bus.imm_src  = 2'b10;
        bus.pc_src   = r_cond_ex;
        bus.pc_write = r_cond_ex;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc_controller
// Purpose : Directed self-checking bench for mc_controller. Walks a fixed
//           instruction sequence cycle by cycle and compares the packed
//           control outputs against hand-computed values each cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  // Packed output bit positions:
  // {ir_write, pc_write, pc_src, adr_src, mem_req, mem_write, reg_write,
  //  mem_to_reg, alu_src, imm_src[1:0], reg_src[1:0], alu_control[2:0],
  //  shift_flag, illegal}
  localparam logic [17:0] IRW    = 18'h20000;
  localparam logic [17:0] PCW    = 18'h10000;
  localparam logic [17:0] PCS    = 18'h08000;
  localparam logic [17:0] ADR    = 18'h04000;
  localparam logic [17:0] MREQ   = 18'h02000;
  localparam logic [17:0] MW     = 18'h01000;
  localparam logic [17:0] RW     = 18'h00800;
  localparam logic [17:0] M2R    = 18'h00400;
  localparam logic [17:0] AS     = 18'h00200;
  localparam logic [17:0] IMM_BR = 18'h00100;
  localparam logic [17:0] IMM_12 = 18'h00080;
  localparam logic [17:0] RS_RD  = 18'h00040;
  localparam logic [17:0] RS_PC  = 18'h00020;
  localparam logic [17:0] A_SUB  = 18'h00004;
  localparam logic [17:0] A_AND  = 18'h00008;
  localparam logic [17:0] A_ORR  = 18'h0000C;
  localparam logic [17:0] A_EOR  = 18'h00010;
  localparam logic [17:0] SH     = 18'h00002;
  localparam logic [17:0] ILL    = 18'h00001;
  localparam logic [17:0] F_OK   = MREQ | IRW | PCW;
  localparam logic [3:0]  FL_JUNK = 4'b0110;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mc_controller_if bus ();

  mc_controller #(.FLAG_RST(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.adr_src, bus.mem_req,
            bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.alu_src,
            bus.imm_src, bus.reg_src, bus.alu_control, bus.shift_flag,
            bus.illegal};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] got;
    got = outs();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge; drives inputs, checks at the falling
  // edge, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic mr, input logic [17:0] exp,
                     input logic [3:0] fl);
    bus.mem_ready = mr;
    bus.alu_flags = fl;
    #4;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    bus.cond  = c;
    bus.op    = o;
    bus.funct = f;
    bus.rd    = r;
  endtask

  task automatic branch(input string tag, input logic [3:0] c, input logic taken);
    set_instr(c, 2'b10, 6'b000000, 4'd0);
    cyc({tag, "_fetch"},  1'b1, F_OK, FL_JUNK);
    cyc({tag, "_decode"}, 1'b1, RS_PC, FL_JUNK);
    cyc({tag, "_branch"}, 1'b1, AS | IMM_BR | (taken ? (PCS | PCW) : 18'h0), FL_JUNK);
  endtask

  // Data-processing: FETCH, DECODE, EXEC (flags presented), ALUWB
  task automatic dp(input string tag, input logic [3:0] c, input logic [5:0] f,
                    input logic [3:0] r, input logic [3:0] fl,
                    input logic [17:0] e_exec, input logic [17:0] e_wb);
    set_instr(c, 2'b00, f, r);
    cyc({tag, "_fetch"},  1'b1, F_OK, FL_JUNK);
    cyc({tag, "_decode"}, 1'b1, 18'h0, FL_JUNK);
    cyc({tag, "_exec"},   1'b1, e_exec, fl);
    cyc({tag, "_aluwb"},  1'b1, e_wb, FL_JUNK);
  endtask

  initial begin
    reset = 1'b0;
    set_instr(4'h0, 2'b00, 6'h00, 4'h0);
    bus.mem_ready = 1'b0;
    bus.alu_flags = 4'h0;

    // Reset held, then released: one RST cycle before FETCH
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", 18'h0);
    reset = 1'b1;
    cyc("rst_state", 1'b1, 18'h0, FL_JUNK);

    // ADD S=1 R1=R2+R3, 0x7FFFFFFF+1 -> NZCV=1001
    dp("add", 4'hE, 6'b001001, 4'd1, 4'b1001, 18'h0, RW);
    branch("bmi_t", 4'b0100, 1'b1);
    branch("bvs_t", 4'b0110, 1'b1);
    branch("beq_n", 4'b0000, 1'b0);
    branch("bcs_n", 4'b0010, 1'b0);
    branch("bnv_n", 4'b1111, 1'b0);
    branch("bge_t", 4'b1010, 1'b1);

    // CMP (imm) sets NZCV=0100
    dp("cmp", 4'hE, 6'b110101, 4'd0, 4'b0100, AS | A_SUB, AS | A_SUB);
    branch("bne_n", 4'b0001, 1'b0);
    branch("beq_t", 4'b0000, 1'b1);
    branch("bgt_n", 4'b1100, 1'b0);
    branch("ble_t", 4'b1101, 1'b1);

    // ANDS: only N,Z update -> NZCV=1000 despite ALU C=V=1
    dp("ands", 4'hE, 6'b000001, 4'd2, 4'b1011, A_AND, RW | A_AND);
    branch("bcs2_n", 4'b0010, 1'b0);
    branch("bvs2_n", 4'b0110, 1'b0);
    branch("blt_t",  4'b1011, 1'b1);
    branch("bhi_n",  4'b1000, 1'b0);
    branch("bls_t",  4'b1001, 1'b1);

    // LDR with two wait cycles in FETCH and in MEMRD: 9 cycles total
    set_instr(4'hE, 2'b01, 6'b011001, 4'd4);
    cyc("ldr_f_w0", 1'b0, MREQ, FL_JUNK);
    cyc("ldr_f_w1", 1'b0, MREQ, FL_JUNK);
    cyc("ldr_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("ldr_decode", 1'b1, RS_RD, FL_JUNK);
    cyc("ldr_memadr", 1'b1, AS | IMM_12, FL_JUNK);
    cyc("ldr_rd_w0", 1'b0, MREQ | ADR, FL_JUNK);
    cyc("ldr_rd_w1", 1'b0, MREQ | ADR, FL_JUNK);
    cyc("ldr_memrd", 1'b1, MREQ | ADR, FL_JUNK);
    cyc("ldr_memwb", 1'b1, RW | M2R, FL_JUNK);

    // STREQ with Z=0: squashed, leaves MEMWR without mem_ready
    set_instr(4'h0, 2'b01, 6'b010000, 4'd3);
    cyc("streq_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("streq_decode", 1'b1, RS_RD, FL_JUNK);
    cyc("streq_memadr", 1'b1, AS | IMM_12, FL_JUNK);
    cyc("streq_memwr", 1'b0, ADR, FL_JUNK);

    // STR (U=0 -> SUB) with one wait cycle in MEMWR
    set_instr(4'hE, 2'b01, 6'b000000, 4'd5);
    cyc("str_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("str_decode", 1'b1, RS_RD, FL_JUNK);
    cyc("str_memadr", 1'b1, AS | IMM_12 | A_SUB, FL_JUNK);
    cyc("str_wr_w0", 1'b0, MREQ | ADR | MW, FL_JUNK);
    cyc("str_memwr", 1'b1, MREQ | ADR | MW, FL_JUNK);

    // LDR into PC
    set_instr(4'hE, 2'b01, 6'b000001, 4'd15);
    cyc("ldrpc_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("ldrpc_decode", 1'b1, RS_RD, FL_JUNK);
    cyc("ldrpc_memadr", 1'b1, AS | IMM_12 | A_SUB, FL_JUNK);
    cyc("ldrpc_memrd", 1'b1, MREQ | ADR, FL_JUNK);
    cyc("ldrpc_memwb", 1'b1, RW | M2R | PCS | PCW, FL_JUNK);

    // MOV pc, #imm
    dp("movpc", 4'hE, 6'b111010, 4'd15, FL_JUNK, AS | SH, RW | PCS | PCW | AS | SH);
    dp("orr", 4'hE, 6'b011000, 4'd6, FL_JUNK, A_ORR, RW | A_ORR);
    dp("eor", 4'hE, 6'b000010, 4'd7, FL_JUNK, A_EOR, RW | A_EOR);
    // Condition never: no register or PC write
    dp("subnv", 4'hF, 6'b000100, 4'd15, FL_JUNK, A_SUB, A_SUB);

    // op=11: illegal pulse in DECODE, straight back to FETCH
    set_instr(4'hE, 2'b11, 6'b000000, 4'd0);
    cyc("op11_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("op11_decode", 1'b1, ILL, FL_JUNK);
    // Undefined data-processing cmd: illegal in EXEC, back to FETCH
    set_instr(4'hE, 2'b00, 6'b000110, 4'd0);
    cyc("badcmd_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("badcmd_decode", 1'b1, 18'h0, FL_JUNK);
    cyc("badcmd_exec", 1'b1, ILL, FL_JUNK);

    // Set Z, then reset asynchronously in the middle of a load
    dp("cmp2", 4'hE, 6'b110101, 4'd0, 4'b0100, AS | A_SUB, AS | A_SUB);
    set_instr(4'hE, 2'b01, 6'b011001, 4'd8);
    cyc("ldr2_fetch", 1'b1, F_OK, FL_JUNK);
    cyc("ldr2_decode", 1'b1, RS_RD, FL_JUNK);
    cyc("ldr2_memadr", 1'b1, AS | IMM_12, FL_JUNK);
    cyc("ldr2_rd_w0", 1'b0, MREQ | ADR, FL_JUNK);
    #2;
    check("ldr2_rd_w1", MREQ | ADR);
    reset = 1'b0;
    #1;
    check("rst_async", 18'h0);
    @(posedge clk); #1;
    check("rst_low_edge", 18'h0);
    reset = 1'b1;
    cyc("rst_release", 1'b1, 18'h0, FL_JUNK);
    // Flags cleared by reset: Z=0
    branch("beq_after_rst", 4'b0000, 1'b0);
    branch("bne_after_rst", 4'b0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
